// File: rtl/sram_like_arbiter.sv
// Two-port to one SRAM-like arbiter: inst_* and data_* share the mem_* port, and an in-order tag FIFO routes each response back to its issuer.
// Define ARB_RR_EN for round-robin arbitration; otherwise the data port has fixed priority.
module sram_like_arbiter #(
    parameter int MAX_OUTST = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic        err_resp
);

    localparam int              PTR_W    = $clog2(MAX_OUTST);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(MAX_OUTST);

    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } src_t;

    src_t             r_tag [MAX_OUTST];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;
    logic             r_lock_vld;
    src_t             r_lock_src;
    logic             r_err;
`ifdef ARB_RR_EN
    src_t             r_last_grant;
`endif

    src_t w_grant;
    src_t w_head_src;
    logic w_lock_req;
    logic w_src_req;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_stray;

    // A stalled (locked) source keeps the grant so the bridge sees a stable payload.
    always_comb begin
        w_lock_req = (r_lock_src == SRC_DATA) ? data_req : inst_req;
        w_grant    = SRC_INST;
        if (r_lock_vld && w_lock_req)
            w_grant = r_lock_src;
`ifdef ARB_RR_EN
        else if (inst_req && data_req)
            w_grant = (r_last_grant == SRC_DATA) ? SRC_INST : SRC_DATA;
`endif
        else if (data_req)
            w_grant = SRC_DATA;
        else
            w_grant = SRC_INST;
    end

    // Full check uses the registered count only, so a same-cycle pop does not free a slot.
    assign w_src_req = (w_grant == SRC_DATA) ? data_req : inst_req;
    assign w_full    = (r_count == CNT_FULL);
    assign mem_req   = !reset && !w_full && w_src_req;

    assign mem_wr    = (w_grant == SRC_DATA) ? data_wr    : inst_wr;
    assign mem_size  = (w_grant == SRC_DATA) ? data_size  : inst_size;
    assign mem_wstrb = (w_grant == SRC_DATA) ? data_wstrb : inst_wstrb;
    assign mem_addr  = (w_grant == SRC_DATA) ? data_addr  : inst_addr;
    assign mem_wdata = (w_grant == SRC_DATA) ? data_wdata : inst_wdata;

    assign w_push       = mem_req && mem_addr_ok;
    assign inst_addr_ok = w_push && (w_grant == SRC_INST);
    assign data_addr_ok = w_push && (w_grant == SRC_DATA);

    assign w_head_src   = r_tag[r_head];
    assign w_pop        = !reset && mem_data_ok && (r_count != '0);
    assign w_stray      = !reset && mem_data_ok && (r_count == '0);
    assign inst_data_ok = w_pop && (w_head_src == SRC_INST);
    assign data_data_ok = w_pop && (w_head_src == SRC_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;
    assign err_resp     = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_lock_vld <= 1'b0;
            r_lock_src <= SRC_INST;
            r_err      <= 1'b0;
        end else begin
            if (w_push)
                r_tail <= r_tail + PTR_ONE;
            if (w_pop)
                r_head <= r_head + PTR_ONE;
            if (w_push && !w_pop)
                r_count <= r_count + CNT_ONE;
            else if (!w_push && w_pop)
                r_count <= r_count - CNT_ONE;

            if (mem_req && !mem_addr_ok) begin
                r_lock_vld <= 1'b1;
                r_lock_src <= w_grant;
            end else if (w_push || (r_lock_vld && !w_lock_req)) begin
                r_lock_vld <= 1'b0;
            end

            if (w_stray)
                r_err <= 1'b1;
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge clk) begin
        if (reset)
            r_last_grant <= SRC_INST;
        else if (w_push)
            r_last_grant <= w_grant;
    end
`endif

    // Tag storage holds only data; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push)
            r_tag[r_tail] <= w_grant;
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: directed vector table, hand-written full/reset sequences,
// and a randomized run checked against a queue-based reference model.
module tb_sram_like_arbiter;

    localparam int MAX_OUTST = 4;
    localparam logic [31:0] IA = 32'h1c00_0000;
    localparam logic [31:0] DA = 32'h8000_1000;
`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic        err_resp;

    sram_like_arbiter #(.MAX_OUTST(MAX_OUTST)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .err_resp(err_resp)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic rst, input logic ir, input logic dr,
                         input logic aok, input logic dok, input logic [31:0] rd);
        reset       = rst;
        inst_req    = ir;
        data_req    = dr;
        mem_addr_ok = aok;
        mem_data_ok = dok;
        mem_rdata   = rd;
    endtask

    // Checks outputs mid-cycle, then advances to just after the next rising edge.
    task automatic expect_out(input string tag, input logic mreq, input logic [31:0] maddr,
                              input logic iaok, input logic daok, input logic idok,
                              input logic ddok, input logic err, input logic [31:0] rd);
        @(negedge clk);
        chk_b($sformatf("%s mem_req", tag), mem_req, mreq);
        if (mreq) chk_w($sformatf("%s mem_addr", tag), mem_addr, maddr);
        chk_b($sformatf("%s inst_addr_ok", tag), inst_addr_ok, iaok);
        chk_b($sformatf("%s data_addr_ok", tag), data_addr_ok, daok);
        chk_b($sformatf("%s inst_data_ok", tag), inst_data_ok, idok);
        chk_b($sformatf("%s data_data_ok", tag), data_data_ok, ddok);
        chk_b($sformatf("%s err_resp", tag), err_resp, err);
        if (idok) chk_w($sformatf("%s inst_rdata", tag), inst_rdata, rd);
        if (ddok) chk_w($sformatf("%s data_rdata", tag), data_rdata, rd);
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic        rst, ir, dr, aok, dok;
        logic [31:0] rd;
        logic        mreq;
        logic [31:0] maddr;
        logic        iaok, daok, idok, ddok, err;
    } vec_t;

    vec_t tbl[$];

    task automatic addv(input logic rst, input logic ir, input logic dr, input logic aok,
                        input logic dok, input logic [31:0] rd, input logic mreq,
                        input logic [31:0] maddr, input logic iaok, input logic daok,
                        input logic idok, input logic ddok, input logic err);
        vec_t v;
        v = '{rst, ir, dr, aok, dok, rd, mreq, maddr, iaok, daok, idok, ddok, err};
        tbl.push_back(v);
    endtask

    // Reference model state: outstanding sources in issue order, stalled source, sticky error.
    bit q[$];
    bit m_held, m_held_src, m_last, m_err;

    initial begin
        logic [31:0] rd;
        bit          full, g, mreq, resp, head;

        inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'hf; inst_addr = IA; inst_wdata = '0;
        data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'hf; data_addr = DA; data_wdata = '0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        repeat (3) @(posedge clk);
        #1;

        // rst ir dr aok dok rdata | mreq maddr iaok daok idok ddok err
        addv(1,1,1,1,1,32'h0,          0,'0,0,0,0,0,0);
        addv(0,1,0,1,0,32'h0,          1,IA,1,0,0,0,0);
        addv(0,0,0,1,0,32'h0,          0,'0,0,0,0,0,0);
        addv(0,0,0,0,1,32'h0280_0000,  0,'0,0,0,1,0,0);
        addv(0,1,1,1,0,32'h0,          1,DA,0,1,0,0,0);
        addv(0,1,0,1,0,32'h0,          1,IA,1,0,0,0,0);
        addv(0,0,0,0,1,32'haaaa_0001,  0,'0,0,0,0,1,0);
        addv(0,0,0,0,1,32'hbbbb_0002,  0,'0,0,0,1,0,0);
        addv(0,0,1,0,0,32'h0,          1,DA,0,0,0,0,0);
        addv(0,1,1,0,0,32'h0,          1,DA,0,0,0,0,0);
        addv(0,1,1,0,0,32'h0,          1,DA,0,0,0,0,0);
        addv(0,1,1,1,0,32'h0,          1,DA,0,1,0,0,0);
        addv(0,1,0,1,0,32'h0,          1,IA,1,0,0,0,0);
        addv(0,0,0,0,1,32'hc0de_0013,  0,'0,0,0,0,1,0);
        addv(0,0,0,0,1,32'hc0de_0014,  0,'0,0,0,1,0,0);
        addv(0,1,0,0,0,32'h0,          1,IA,0,0,0,0,0);
        addv(0,1,1,0,0,32'h0,          1,IA,0,0,0,0,0);
        addv(0,1,1,1,0,32'h0,          1,IA,1,0,0,0,0);
        addv(0,0,1,1,0,32'h0,          1,DA,0,1,0,0,0);
        addv(0,0,0,0,1,32'hc0de_0019,  0,'0,0,0,1,0,0);
        addv(0,0,0,0,1,32'hc0de_0020,  0,'0,0,0,0,1,0);
        addv(0,0,0,0,1,32'h0,          0,'0,0,0,0,0,0);
        addv(0,0,0,0,0,32'h0,          0,'0,0,0,0,0,1);
        addv(0,1,0,1,0,32'h0,          1,IA,1,0,0,0,1);
        addv(0,0,0,0,1,32'hdead_0024,  0,'0,0,0,1,0,1);
        addv(0,1,0,0,0,32'h0,          1,IA,0,0,0,0,1);
        addv(0,0,1,1,0,32'h0,          1,DA,0,1,0,0,1);
        addv(0,0,0,0,1,32'hdead_0027,  0,'0,0,0,0,1,1);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].ir, tbl[i].dr, tbl[i].aok, tbl[i].dok, tbl[i].rd);
            expect_out($sformatf("vec%0d", i), tbl[i].mreq, tbl[i].maddr, tbl[i].iaok,
                       tbl[i].daok, tbl[i].idok, tbl[i].ddok, tbl[i].err, tbl[i].rd);
        end

        // Fill to MAX_OUTST, then a pop and a request in the same cycle.
        drive(1, 0, 0, 0, 0, '0);
        expect_out("full_rst", 0, '0, 0, 0, 0, 0, 1, '0);
        for (int i = 0; i < MAX_OUTST; i++) begin
            drive(0, 0, 1, 1, 0, '0);
            expect_out($sformatf("fill%0d", i), 1, DA, 0, 1, 0, 0, 0, '0);
        end
        drive(0, 0, 1, 1, 0, '0);
        expect_out("at_full", 0, '0, 0, 0, 0, 0, 0, '0);
        drive(0, 0, 1, 1, 1, 32'h5555_0001);
        expect_out("full_pop", 0, '0, 0, 0, 0, 1, 0, 32'h5555_0001);
        drive(0, 0, 1, 1, 0, '0);
        expect_out("after_pop", 1, DA, 0, 1, 0, 0, 0, '0);
        for (int i = 0; i < MAX_OUTST; i++) begin
            drive(0, 0, 0, 0, 1, 32'h6666_0000 + 32'(i));
            expect_out($sformatf("drain%0d", i), 0, '0, 0, 0, 0, 1, 0, 32'h6666_0000 + 32'(i));
        end

        // Reset with three requests outstanding and the error flag set.
        drive(0, 0, 0, 0, 1, '0);
        expect_out("stray", 0, '0, 0, 0, 0, 0, 0, '0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 1, 0, '0);
            expect_out($sformatf("outst%0d", i), 1, IA, 1, 0, 0, 0, 1, '0);
        end
        drive(1, 1, 1, 1, 1, 32'h7777_0000);
        expect_out("in_rst", 0, '0, 0, 0, 0, 0, 1, '0);
        drive(0, 0, 0, 0, 0, '0);
        expect_out("post_rst", 0, '0, 0, 0, 0, 0, 0, '0);
        drive(0, 0, 0, 0, 1, 32'h7777_0001);
        expect_out("post_rst_dok", 0, '0, 0, 0, 0, 0, 0, '0);
        drive(0, 0, 0, 0, 0, '0);
        expect_out("post_rst_err", 0, '0, 0, 0, 0, 0, 1, '0);

        // Randomized run against the reference model.
        drive(1, 0, 0, 0, 0, '0);
        @(posedge clk);
        #1;
        q.delete();
        m_held = 0; m_held_src = 0; m_last = 0; m_err = 0;
        for (int c = 0; c < 3000; c++) begin
            reset       = ($urandom_range(0, 199) == 0);
            inst_req    = ($urandom_range(0, 99) < 60);
            data_req    = ($urandom_range(0, 99) < 55);
            mem_addr_ok = ($urandom_range(0, 99) < 60);
            mem_data_ok = ($urandom_range(0, 99) < 45);
            rd          = $urandom;
            mem_rdata   = rd;
            inst_wr = 1'($urandom); inst_size = 2'($urandom); inst_wstrb = 4'($urandom);
            inst_addr = $urandom; inst_wdata = $urandom;
            data_wr = 1'($urandom); data_size = 2'($urandom); data_wstrb = 4'($urandom);
            data_addr = $urandom; data_wdata = $urandom;

            full = (q.size() == MAX_OUTST);
            if (m_held && (m_held_src ? data_req : inst_req)) g = m_held_src;
            else if (RR && inst_req && data_req) g = !m_last;
            else g = data_req;
            mreq = !reset && !full && (g ? data_req : inst_req);
            resp = !reset && mem_data_ok && (q.size() > 0);
            head = (q.size() > 0) ? q[0] : 1'b0;

            @(negedge clk);
            chk_b("rnd mem_req", mem_req, mreq);
            chk_b("rnd inst_addr_ok", inst_addr_ok, mreq && mem_addr_ok && !g);
            chk_b("rnd data_addr_ok", data_addr_ok, mreq && mem_addr_ok && g);
            chk_b("rnd inst_data_ok", inst_data_ok, resp && !head);
            chk_b("rnd data_data_ok", data_data_ok, resp && head);
            chk_b("rnd err_resp", err_resp, m_err);
            if (mreq) begin
                chk_w("rnd mem_addr", mem_addr, g ? data_addr : inst_addr);
                chk_w("rnd mem_wdata", mem_wdata, g ? data_wdata : inst_wdata);
                chk_w("rnd mem_ctl", {25'b0, mem_wr, mem_size, mem_wstrb},
                      g ? {25'b0, data_wr, data_size, data_wstrb} : {25'b0, inst_wr, inst_size, inst_wstrb});
            end
            if (resp) chk_w("rnd rdata", head ? data_rdata : inst_rdata, rd);

            if (reset) begin
                q.delete();
                m_held = 0; m_held_src = 0; m_last = 0; m_err = 0;
            end else begin
                if (resp) void'(q.pop_front());
                else if (mem_data_ok) m_err = 1;
                if (mreq && mem_addr_ok) begin
                    q.push_back(g);
                    m_last = g;
                    m_held = 0;
                end else if (mreq) begin
                    m_held = 1;
                    m_held_src = g;
                end else if (m_held && !(m_held_src ? data_req : inst_req)) begin
                    m_held = 0;
                end
            end
            @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
